activation_pipe: RTL and testbench
==================================

// Module: activation_pipe
// PURPOSE
//  Streaming multi-lane activation stage; successor of the single-value clocked ReLU/linear unit.
//  Applies one of four per-beat modes to LANES signed fixed-point values: linear, ReLU, leaky ReLU, clamped ReLU.
//  Valid/ready in and out, 2-stage elastic pipeline, 1 beat/cycle; sits between the MAC accumulator buffer and the writeback FIFO.
// PARAMETERS
//  DATA_W      16  width of one signed lane value (two's complement)
//  LANES       4   values per beat; in_data/out_data are LANES*DATA_W, lane i at [i*DATA_W +: DATA_W]
//  SHIFT_W     4   width of cfg_leak_shift
// PORTS
//  clk             in   1               rising-edge clock
//  rst_n           in   1               asynchronous active-low reset
//  in_valid        in   1               input beat valid
//  in_ready        out  1               stage 1 can accept a beat
//  in_data         in   LANES*DATA_W    packed signed lanes
//  in_mode         in   2               0 linear, 1 ReLU, 2 leaky, 3 clamp; sampled with the beat
//  in_last         in   1               end-of-row marker, passed through
//  cfg_clip        in   DATA_W          signed clamp ceiling for mode 3; sampled with the beat
//  cfg_leak_shift  in   SHIFT_W         negative-slope shift for mode 2; sampled with the beat
//  out_valid       out  1               output beat valid
//  out_ready       in   1               downstream accepts
//  out_data        out  LANES*DATA_W    activated lanes
//  out_last        out  1               in_last of this beat
//  out_clipped     out  LANES           lane i was limited by clip (mode 3, x > clip)
//  busy            out  1               any stage holds a beat
// BEHAVIOUR
//  - Reset (rst_n=0, async): both stage valids 0; out_valid, out_data, out_last, out_clipped, busy = 0.
//    in_ready = 0 while rst_n=0, 1 from the first clock after release. In-flight beats are dropped, no partial output.
//  - Handshake: transfer when valid && ready on a rising edge. out_valid, once high, stays high with
//    out_data/out_last/out_clipped stable until out_ready. in_ready never depends combinationally on in_valid.
//  - Pipeline: S1 registers data/mode/last/clip/shift; S2 registers the activated result (= outputs).
//    adv2 = !s2_v || out_ready; adv1 = !s1_v || (s1_v && adv2); in_ready = adv1.
//    Latency 2 cycles in->out with no stall; full rate with out_ready held 1; no bubbles, no drops, order kept.
//  - Modes per lane, x signed DATA_W:
//    0 linear: y = x.
//    1 ReLU:   y = (x < 0) ? 0 : x.
//    2 leaky:  y = (x < 0) ? x >>> s : x, s = min(cfg_leak_shift, DATA_W-1); s=0 gives identity; floor rounding.
//    3 clamp:  c = (cfg_clip < 0) ? 0 : cfg_clip; y = (x < 0) ? 0 : (x > c) ? c : x; out_clipped[i] = (x > c).
//    out_clipped = 0 in modes 0-2. No widening; results always fit DATA_W.
//  - Boundaries: x = most negative -> ReLU 0, leaky s=DATA_W-1 -> -1; x = c -> not clipped;
//    cfg change mid-stream affects only beats accepted after it; simultaneous accept on in and out
//    with both stages full keeps full occupancy; out_ready low indefinitely stalls without loss.
//  - busy = s1_v | s2_v.
// STRUCTURE
//  - act_pkg: typedef enum logic [1:0] act_mode_e {ACT_LINEAR, ACT_RELU, ACT_LEAKY, ACT_CLAMP};
//    the stage record struct (data, mode, last, clip, shift) is parameterised locally.
//  - Sub-module act_lane: combinational single-lane function (x, mode, clip, shift -> y, clipped),
//    generate-instantiated LANES times between S1 and S2. Handshake/control logic lives in the top.
// TESTING
//  1. Reset: rst_n=0 mid-stream with 2 beats in flight -> outputs 0 asynchronously, no beat appears after release.
//  2. Mode 1, lanes {-5, 0, 7, -32768}, out_ready=1 -> {0, 0, 7, 0} exactly 2 cycles after accept.
//  3. Mode 2, shift=2, lanes {-8, -1, 12, -32768} -> {-2, -1, 12, -8192}; shift=15 on -32768 -> -1.
//  4. Mode 3, clip=100, lanes {150, 100, -3, 50} -> {100, 100, 0, 50}, out_clipped=4'b0001; clip=-7 -> all 0.
//  5. 64 random beats, random modes, out_ready toggled randomly -> scoreboard matches golden model,
//     order and out_last preserved, out_data stable while out_valid && !out_ready.
//  6. Back-to-back 16 beats, out_ready=1 -> in_ready never drops, 16 outputs in 16 consecutive cycles.

Source files
------------

// File: rtl/act_pkg.sv
// act_pkg: shared mode encoding for the activation pipeline.
package act_pkg;
    typedef enum logic [1:0] {ACT_LINEAR, ACT_RELU, ACT_LEAKY, ACT_CLAMP} act_mode_e;
endpackage

// File: rtl/activation_pipe_if.sv
// activation_pipe_if: in/out valid-ready streams plus per-beat config and status.
interface activation_pipe_if #(
    parameter int DATA_W  = 16,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic [1:0]              in_mode;
    logic                    in_last;
    logic [DATA_W-1:0]       cfg_clip;
    logic [SHIFT_W-1:0]      cfg_leak_shift;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic                    out_last;
    logic [LANES-1:0]        out_clipped;
    logic                    busy;
    modport master (
        output in_valid, in_data, in_mode, in_last, cfg_clip, cfg_leak_shift, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_clipped, busy
    );
    modport slave (
        input  in_valid, in_data, in_mode, in_last, cfg_clip, cfg_leak_shift, out_ready,
        output in_ready, out_valid, out_data, out_last, out_clipped, busy
    );
endinterface

// File: rtl/act_lane.sv
// act_lane: combinational single-lane activation (linear / ReLU / leaky / clamp).
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = 4
) (
    input  logic signed [DATA_W-1:0]  x_i,
    input  act_mode_e                 mode_i,
    input  logic signed [DATA_W-1:0]  clip_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    output logic signed [DATA_W-1:0]  y_o,
    output logic                      clipped_o
);
    logic signed [DATA_W-1:0] c;
    logic signed [DATA_W-1:0] leak;
    logic                     neg;
    logic                     over;
    int unsigned              s;
    always_comb begin
        s    = (32'(shift_i) > 32'(DATA_W - 1)) ? 32'(DATA_W - 1) : 32'(shift_i);
        neg  = x_i[DATA_W-1];
        c    = clip_i[DATA_W-1] ? '0 : clip_i;
        over = x_i > c;
        leak = x_i >>> s;
        y_o  = (mode_i == ACT_LINEAR) ? x_i :
               (mode_i == ACT_RELU)   ? (neg ? '0 : x_i) :
               (mode_i == ACT_LEAKY)  ? (neg ? leak : x_i) :
               (neg ? '0 : over ? c : x_i);
        clipped_o = (mode_i == ACT_CLAMP) && over;
    end
endmodule

// File: rtl/activation_pipe.sv
// activation_pipe: two-stage elastic valid/ready pipeline applying a per-beat activation to LANES lanes.
module activation_pipe
    import act_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 4
) (
    input logic          clk,
    input logic          rst_n,
    activation_pipe_if.slave p
);
    typedef struct packed {
        logic [LANES*DATA_W-1:0] data;
        act_mode_e               mode;
        logic                    last;
        logic [DATA_W-1:0]       clip;
        logic [SHIFT_W-1:0]      shift;
    } s1_t;

    s1_t                     s1_q, s1_d;
    logic                    s1_v_q, s2_v_q, rdy_q;
    logic                    adv1, adv2, acc;
    logic [LANES*DATA_W-1:0] y_d, out_data_q;
    logic [LANES-1:0]        clp_d, out_clipped_q;
    logic                    out_last_q;

    // rdy_q holds in_ready low through reset and until the first clock after release
    assign adv2       = !s2_v_q || p.out_ready;
    assign adv1       = !s1_v_q || adv2;
    assign p.in_ready = rdy_q && adv1;
    assign acc        = p.in_valid && p.in_ready;
    assign s1_d       = '{data: p.in_data, mode: act_mode_e'(p.in_mode), last: p.in_last,
                          clip: p.cfg_clip, shift: p.cfg_leak_shift};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_lane #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) u_lane (
            .x_i      (s1_q.data[i*DATA_W +: DATA_W]),
            .mode_i   (s1_q.mode),
            .clip_i   (s1_q.clip),
            .shift_i  (s1_q.shift),
            .y_o      (y_d[i*DATA_W +: DATA_W]),
            .clipped_o(clp_d[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q         <= 1'b0;
            s1_v_q        <= 1'b0;
            s2_v_q        <= 1'b0;
            s1_q          <= '0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_clipped_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (adv1) s1_v_q <= acc;
            if (acc) s1_q <= s1_d;
            if (adv2) s2_v_q <= s1_v_q;
            if (adv2 && s1_v_q) begin
                out_data_q    <= y_d;
                out_last_q    <= s1_q.last;
                out_clipped_q <= clp_d;
            end
        end
    end

    assign p.out_valid   = s2_v_q;
    assign p.out_data    = out_data_q;
    assign p.out_last    = out_last_q;
    assign p.out_clipped = out_clipped_q;
    assign p.busy        = s1_v_q | s2_v_q;
endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: directed vector table, reset/stall/burst sequences and a randomised scoreboard run.
module tb_activation_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    activation_pipe_if bus ();
    activation_pipe dut (.clk(clk), .rst_n(rst_n), .p(bus.slave));

    typedef struct {
        logic [1:0]  m;
        logic [15:0] clip;
        logic [3:0]  sh;
        logic [63:0] din;
        logic [63:0] dout;
        logic [3:0]  clp;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        last;
        logic [3:0]  c;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_out = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    bit mon_en = 1'b0;
    bit drv_done = 1'b0;
    exp_t sbq[$];
    vec_t vecs[10];
    logic        hold_v = 1'b0;
    logic [63:0] hold_d;
    logic [3:0]  hold_c;
    logic        hold_l;

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // independent golden model: floor shift written as ceiling-divide of the magnitude
    function automatic exp_t model(input logic [63:0] d, input logic [1:0] m, input logic [15:0] clip,
                                   input logic [3:0] sh, input logic last);
        exp_t e;
        int x, y, cc, s;
        cc = ($signed(clip) < 0) ? 0 : int'($signed(clip));
        s = (int'(sh) > 15) ? 15 : int'(sh);
        e.last = last;
        e.c = '0;
        e.d = '0;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(d[i*16 +: 16]));
            case (m)
                2'd0: y = x;
                2'd1: y = (x < 0) ? 0 : x;
                2'd2: y = (x < 0) ? -((-x + (1 << s) - 1) / (1 << s)) : x;
                default: begin
                    y = (x < 0) ? 0 : (x > cc) ? cc : x;
                    e.c[i] = (x > cc);
                end
            endcase
            e.d[i*16 +: 16] = 16'(y);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.in_valid && bus.in_ready)
                sbq.push_back(model(bus.in_data, bus.in_mode, bus.cfg_clip, bus.cfg_leak_shift, bus.in_last));
            if (hold_v) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, hold_d);
                chk("stall_clip", bus.out_clipped, hold_c);
                chk("stall_last", bus.out_last, hold_l);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra got output %h expected none", bus.out_data);
                end else begin
                    chk("sb_data", bus.out_data, sbq[0].d);
                    chk("sb_clip", bus.out_clipped, sbq[0].c);
                    chk("sb_last", bus.out_last, sbq[0].last);
                    void'(sbq.pop_front());
                end
                if (n_out == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
            end
            hold_v = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data;
            hold_c = bus.out_clipped;
            hold_l = bus.out_last;
        end
    end

    task automatic drive(input logic [63:0] d, input logic [1:0] m, input logic [15:0] clip,
                         input logic [3:0] sh, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_mode = m;
        bus.cfg_clip = clip;
        bus.cfg_leak_shift = sh;
        bus.in_last = last;
    endtask

    task automatic send_vec(input vec_t v, input logic last, input string n);
        @(posedge clk); #1;
        drive(v.din, v.m, v.clip, v.sh, last);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({n, "_rdy"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({n, "_early"}, bus.out_valid, 0);
        @(negedge clk);
        chk({n, "_valid"}, bus.out_valid, 1);
        chk({n, "_data"}, bus.out_data, v.dout);
        chk({n, "_clip"}, bus.out_clipped, v.clp);
        chk({n, "_last"}, bus.out_last, last);
    endtask

    initial begin
        int seen, t, drops;
        vecs[0] = '{2'd1, 16'd0, 4'd0, pk(-5, 0, 7, -32768), pk(0, 0, 7, 0), 4'b0000};
        vecs[1] = '{2'd2, 16'd0, 4'd2, pk(-8, -1, 12, -32768), pk(-2, -1, 12, -8192), 4'b0000};
        vecs[2] = '{2'd2, 16'd0, 4'd15, pk(-32768, -1, 5, -2), pk(-1, -1, 5, -1), 4'b0000};
        vecs[3] = '{2'd2, 16'd0, 4'd0, pk(-3, -32768, 9, 0), pk(-3, -32768, 9, 0), 4'b0000};
        vecs[4] = '{2'd3, 16'd100, 4'd0, pk(150, 100, -3, 50), pk(100, 100, 0, 50), 4'b0001};
        vecs[5] = '{2'd3, 16'hFFF9, 4'd0, pk(150, 100, -3, 50), pk(0, 0, 0, 0), 4'b1011};
        vecs[6] = '{2'd0, 16'd5, 4'd3, pk(-32768, 32767, 1, -1), pk(-32768, 32767, 1, -1), 4'b0000};
        vecs[7] = '{2'd3, 16'd32767, 4'd0, pk(32767, -32768, 0, 1000), pk(32767, 0, 0, 1000), 4'b0000};
        vecs[8] = '{2'd3, 16'd0, 4'd0, pk(1, 0, -1, 2), pk(0, 0, 0, 0), 4'b1001};
        vecs[9] = '{2'd1, 16'd1, 4'd7, pk(32767, -1, 1, 300), pk(32767, 0, 1, 300), 4'b0000};

        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_mode = '0;
        bus.in_last = 1'b0;
        bus.cfg_clip = '0;
        bus.cfg_leak_shift = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_clip", bus.out_clipped, 0);
        chk("rst_out_last", bus.out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", bus.in_ready, 0);
        @(posedge clk); #1;
        chk("rel_in_ready_post", bus.in_ready, 1);

        for (int i = 0; i < 10; i++) send_vec(vecs[i], i[0], $sformatf("vec%0d", i));

        // two beats in flight, then asynchronous reset mid-cycle
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(pk(1, 2, 3, 4), 2'd0, 16'd0, 4'd0, 1'b1);
        @(posedge clk); #1;
        drive(pk(5, 6, 7, 8), 2'd0, 16'd0, 4'd0, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("fill_busy", bus.busy, 1);
        chk("fill_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("arst_no_ghost", seen, 0);

        // randomised run with random backpressure
        hold_v = 1'b0;
        n_out = 0;
        mon_en = 1'b1;
        drv_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 64; n++) begin
                    @(posedge clk); #1;
                    while ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    drive({$urandom, $urandom}, 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20000)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                    t = 0;
                    do begin
                        @(negedge clk);
                        t++;
                    end while (!bus.in_ready && t < 200);
                    if (t >= 200) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_accept_timeout got ready 0 expected 1");
                    end
                end
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        for (t = 0; t < 200 && (sbq.size() != 0 || bus.busy); t++) @(negedge clk);
        chk("rand_drain", sbq.size(), 0);
        chk("rand_count", n_out, 64);

        // back-to-back burst at full rate
        @(posedge clk); #1;
        n_out = 0;
        drops = 0;
        for (int n = 0; n < 16; n++) begin
            drive({$urandom, $urandom}, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 30000)),
                  4'($urandom_range(0, 15)), 1'(n == 15));
            @(negedge clk);
            if (!bus.in_ready) drops++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        for (t = 0; t < 50 && (sbq.size() != 0 || bus.busy); t++) @(negedge clk);
        chk("burst_ready_held", drops, 0);
        chk("burst_count", n_out, 16);
        chk("burst_span", last_cyc - first_cyc, 15);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
